mold_req_sched: RTL and testbench
=================================

MOLD_REQ_SCHED -- requirements
Module: mold_req_sched

Interface
REQ-001 Parameters: AXI_DATA_W, 64, stream data width; AXI_KEEP_W, AXI_DATA_W/8, byte-keep width; SID_W, 80, session id width; SEQ_NUM_W, 64, sequence number width; ML_W, 16, message-count width; FIFO_DEPTH, 4, pending-gap entries; MAX_REQ_CNT, 16'hfffe, max messages per request; GAP_CYCLES, 16, idle cycles between requests.
REQ-002 Ports (name  direction  width  meaning), one clock; reset is asynchronous and active-low (clk, nreset):
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 nreset  in  1  asynchronous active-low reset.
REQ-005 miss_seq_num_v_i  in  1  gap report valid, one-cycle pulse from miss detector.
REQ-006 miss_seq_num_sid_i  in  SID_W  session of the gap.
REQ-007 miss_seq_num_start_i  in  SEQ_NUM_W  first missing sequence number.
REQ-008 miss_seq_num_cnt_i  in  SEQ_NUM_W  number of missing messages.
REQ-009 req_axis_tvalid_o / tdata_o / tkeep_o / tlast_o  out  1/AXI_DATA_W/AXI_KEEP_W/1  request packet stream.
REQ-010 req_axis_tready_i  in  1  downstream ready.
REQ-011 req_drop_o  out  1  one-cycle pulse: gap report discarded.
REQ-012 req_busy_o  out  1  FIFO non-empty or FSM not IDLE.

Function
REQ-013 Gap report with cnt != 0 and FIFO not full SHALL be pushed as {sid, start, cnt} on the valid cycle.
REQ-014 Report with cnt == 0 SHALL be ignored (no push, no drop pulse).
REQ-015 Report while FIFO full SHALL be discarded and req_drop_o pulsed the following cycle; full is judged before any same-cycle pop.
REQ-016 FSM states: IDLE, HDR0, HDR1, HDR2, WAIT.
REQ-017 IDLE->HDR0 when FIFO non-empty and gap timer == 0; on that edge working regs load head entry (first use) or keep the current remainder (continuation).
REQ-018 Request packet = 20-byte vector {cnt[ML_W], seq[SEQ_NUM_W], sid[SID_W]}, sid in LSBs; beat0 = bits[63:0], beat1 = [127:64], beat2 = [159:128] zero-extended, tkeep 8'h0F, tlast=1; beats 0/1 tkeep 8'hFF, tlast=0.
REQ-019 Per-request cnt = min(remaining, MAX_REQ_CNT); seq = current start.
REQ-020 tvalid SHALL be high in HDR0-HDR2 only; tdata/tkeep/tlast SHALL hold stable while tvalid & !tready; state advances only on tvalid & tready.
REQ-021 On beat2 acceptance: remaining -= sent cnt, start += sent cnt (mod 2^SEQ_NUM_W wrap); if remaining == 0, pop FIFO.
REQ-022 After beat2 acceptance: GAP_CYCLES > 0 -> WAIT with timer = GAP_CYCLES, decrement each cycle, WAIT->IDLE when timer reaches 1; GAP_CYCLES == 0 -> IDLE directly.
REQ-023 Latency: report on cycle k into empty idle block -> tvalid high on cycle k+2.
REQ-024 Outputs when tvalid low: tdata/tkeep/tlast SHALL be driven 0.

Reset
REQ-025 nreset low SHALL immediately force: FSM IDLE, FIFO empty, timer 0, tvalid/tlast/req_drop_o/req_busy_o 0, tdata/tkeep 0.
REQ-026 Reset mid-packet SHALL truncate the packet (no further beats); pending entries are lost.

Structure
REQ-027 Shared package moldudp64_pkg SHALL hold the FSM state enum, request-header byte length (20), EOS count constant 16'hffff and the gap-entry struct.
REQ-028 FIFO SHALL be sub-module mold_req_fifo (synchronous, FIFO_DEPTH entries, push/pop/full/empty, async active-low reset).
REQ-029 Target size 120-400 lines RTL total.

Verification
REQ-030 Single gap sid=80'hDEADBEEF, start=64'hF0F0F0F0F0F0F0F0, cnt=3, tready=1 -> tvalid at k+2, 3 beats: beat0 = sid[63:0], beat1 = {start[47:0], sid[79:64]}, beat2 = {32'h0, 16'h0003, start[63:48]}, tkeep FF/FF/0F, tlast on beat2 only.
REQ-031 cnt = 64'h1_FFFD (131069), MAX_REQ_CNT=16'hfffe -> three requests: cnt fffe @start, fffe @start+fffe, 1 @start+1fffc; each separated by exactly 16 idle cycles; FIFO pops once.
REQ-032 Five reports back-to-back while tready=0 -> first four queued, fifth gives one req_drop_o pulse; after tready=1, four packets emitted in push order.
REQ-033 tready toggled 1-0-0-1 during beat1 -> beat1 data held constant until accepted; no beat skipped or duplicated.
REQ-034 start=64'hFFFFFFFFFFFFFFFF, cnt=3, MAX_REQ_CNT=2 -> second request seq=64'h1 (wrap), cnt=1; cnt=0 report -> no packet, no drop.
REQ-035 nreset asserted during beat1 -> tvalid low immediately, busy 0; after release, new report produces a full clean 3-beat packet.

Source files
------------

// File: rtl/moldudp64_pkg.sv
// ============================================================================
// Module      : moldudp64_pkg
// Description : Shared definitions for the MoldUDP64 retransmission request
//               path: request-FSM state encoding, request header length,
//               end-of-session message count and the pending-gap entry type.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package moldudp64_pkg;

    // Request scheduler states. Three header beats carry one 20-byte request.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_HDR2 = 3'd3,
        ST_WAIT = 3'd4
    } req_state_e;

    // Request packet is {msg_cnt[16], seq[64], sid[80]} = 20 bytes.
    localparam int          REQ_HDR_BYTES = 20;

    // Message count value that marks end-of-session in a MoldUDP64 header.
    localparam logic [15:0] EOS_MSG_CNT   = 16'hffff;

    // One pending gap as reported by the miss detector (default widths).
    typedef struct packed {
        logic [79:0] sid;
        logic [63:0] start;
        logic [63:0] cnt;
    } gap_entry_t;

endpackage

`default_nettype wire

// File: rtl/mold_req_fifo.sv
// ============================================================================
// Module      : mold_req_fifo
// Description : Small synchronous FIFO holding pending gap entries.
//               Push is ignored when full, pop is ignored when empty.
// Ports       : clk, nreset (async active-low)
//               push_i / push_data_i  - write side
//               pop_i / head_o        - read side (head_o is first-word-fall-through)
//               full_o / empty_o      - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mold_req_fifo
    import moldudp64_pkg::*;
#(
    parameter int WIDTH = 208,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push_ok;
    logic pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mold_req_sched.sv
// ============================================================================
// Module      : mold_req_sched
// Description : Queues gap reports from the miss detector and turns each one
//               into one or more MoldUDP64 retransmission requests, emitted as
//               a 3-beat AXI-stream packet. Large gaps are split into requests
//               of at most MAX_REQ_CNT messages, spaced GAP_CYCLES apart.
// Ports       : clk, nreset (async active-low)
//               miss_seq_num_*_i  - gap report (valid pulse, sid, start, cnt)
//               req_axis_*        - request packet stream
//               req_drop_o        - pulse: report discarded (queue full)
//               req_busy_o        - queue non-empty or request in progress
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mold_req_sched
    import moldudp64_pkg::*;
#(
    parameter int              AXI_DATA_W  = 64,
    parameter int              AXI_KEEP_W  = AXI_DATA_W / 8,
    parameter int              SID_W       = 80,
    parameter int              SEQ_NUM_W   = 64,
    parameter int              ML_W        = 16,
    parameter int              FIFO_DEPTH  = 4,
    parameter logic [ML_W-1:0] MAX_REQ_CNT = 16'hfffe,
    parameter int              GAP_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  nreset,

    input  logic                  miss_seq_num_v_i,
    input  logic [SID_W-1:0]      miss_seq_num_sid_i,
    input  logic [SEQ_NUM_W-1:0]  miss_seq_num_start_i,
    input  logic [SEQ_NUM_W-1:0]  miss_seq_num_cnt_i,

    output logic                  req_axis_tvalid_o,
    output logic [AXI_DATA_W-1:0] req_axis_tdata_o,
    output logic [AXI_KEEP_W-1:0] req_axis_tkeep_o,
    output logic                  req_axis_tlast_o,
    input  logic                  req_axis_tready_i,

    output logic                  req_drop_o,
    output logic                  req_busy_o
);

    localparam int ENTRY_W    = SID_W + 2 * SEQ_NUM_W;
    localparam int VEC_W      = 3 * AXI_DATA_W;
    localparam int LAST_BYTES = REQ_HDR_BYTES - 2 * AXI_KEEP_W;
    localparam logic [AXI_KEEP_W-1:0] KEEP_LAST = AXI_KEEP_W'((1 << LAST_BYTES) - 1);
    localparam int TMR_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    // ------------------------------------------------------------------
    // Pending-gap queue
    // ------------------------------------------------------------------
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] fifo_head;

    logic [SID_W-1:0]     head_sid;
    logic [SEQ_NUM_W-1:0] head_start;
    logic [SEQ_NUM_W-1:0] head_cnt;

    // Full is the registered occupancy flag, so a same-cycle pop never
    // frees a slot for the report arriving in that cycle.
    assign fifo_push = miss_seq_num_v_i && (miss_seq_num_cnt_i != '0) && !fifo_full;

    mold_req_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .nreset      (nreset),
        .push_i      (fifo_push),
        .push_data_i ({miss_seq_num_sid_i, miss_seq_num_start_i, miss_seq_num_cnt_i}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign head_sid   = fifo_head[ENTRY_W-1 -: SID_W];
    assign head_start = fifo_head[2*SEQ_NUM_W-1 -: SEQ_NUM_W];
    assign head_cnt   = fifo_head[SEQ_NUM_W-1:0];

    // ------------------------------------------------------------------
    // Request FSM and working registers
    // ------------------------------------------------------------------
    req_state_e           state_q, state_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [SID_W-1:0]     sid_q, sid_d;
    logic [SEQ_NUM_W-1:0] start_q, start_d;
    logic [SEQ_NUM_W-1:0] rem_q, rem_d;
    logic                 cont_q, cont_d;   // head entry partly sent; keep remainder
    logic                 drop_q, drop_d;

    logic [ML_W-1:0]      send_cnt;
    logic [VEC_W-1:0]     req_vec;

    assign send_cnt = (rem_q > SEQ_NUM_W'(MAX_REQ_CNT)) ? MAX_REQ_CNT : rem_q[ML_W-1:0];

    // sid occupies the LSBs so it leaves on the first beat.
    assign req_vec  = VEC_W'({send_cnt, start_q, sid_q});

    assign drop_d   = miss_seq_num_v_i && (miss_seq_num_cnt_i != '0) && fifo_full;

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        sid_d    = sid_q;
        start_d  = start_q;
        rem_d    = rem_q;
        cont_d   = cont_q;
        fifo_pop = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && (timer_q == '0)) begin
                    state_d = ST_HDR0;
                    if (!cont_q) begin
                        sid_d   = head_sid;
                        start_d = head_start;
                        rem_d   = head_cnt;
                    end
                end
            end
            ST_HDR0: begin
                if (req_axis_tready_i) begin
                    state_d = ST_HDR1;
                end
            end
            ST_HDR1: begin
                if (req_axis_tready_i) begin
                    state_d = ST_HDR2;
                end
            end
            ST_HDR2: begin
                if (req_axis_tready_i) begin
                    rem_d   = rem_q - SEQ_NUM_W'(send_cnt);
                    start_d = start_q + SEQ_NUM_W'(send_cnt);
                    if (rem_d == '0) begin
                        fifo_pop = 1'b1;
                        cont_d   = 1'b0;
                    end else begin
                        cont_d   = 1'b1;
                    end
                    if (GAP_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        timer_d = TMR_W'(GAP_CYCLES);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT: begin
                timer_d = timer_q - TMR_W'(1);
                if (timer_q == TMR_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            sid_q   <= '0;
            start_q <= '0;
            rem_q   <= '0;
            cont_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            sid_q   <= sid_d;
            start_q <= start_d;
            rem_q   <= rem_d;
            cont_q  <= cont_d;
            drop_q  <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Stream outputs: decoded from state, so they hold while stalled and
    // drop to zero the instant reset asserts.
    // ------------------------------------------------------------------
    always_comb begin
        req_axis_tvalid_o = 1'b0;
        req_axis_tdata_o  = '0;
        req_axis_tkeep_o  = '0;
        req_axis_tlast_o  = 1'b0;
        case (state_q)
            ST_HDR0: begin
                req_axis_tvalid_o = 1'b1;
                req_axis_tdata_o  = req_vec[AXI_DATA_W-1:0];
                req_axis_tkeep_o  = '1;
            end
            ST_HDR1: begin
                req_axis_tvalid_o = 1'b1;
                req_axis_tdata_o  = req_vec[2*AXI_DATA_W-1 -: AXI_DATA_W];
                req_axis_tkeep_o  = '1;
            end
            ST_HDR2: begin
                req_axis_tvalid_o = 1'b1;
                req_axis_tdata_o  = req_vec[3*AXI_DATA_W-1 -: AXI_DATA_W];
                req_axis_tkeep_o  = KEEP_LAST;
                req_axis_tlast_o  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign req_drop_o = drop_q;
    assign req_busy_o = !fifo_empty || (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mold_req_sched.sv
// ============================================================================
// Module      : tb_mold_req_sched
// Description : Self-checking bench for mold_req_sched. Two instances: A with
//               default parameters, B with MAX_REQ_CNT=2 and GAP_CYCLES=0.
//               A request-level model predicts every accepted beat and every
//               drop pulse; directed literals pin the model and timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mold_req_sched;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        bit          done;   // last beat of the entry's final request
    } beat_t;

    logic        clk = 1'b0;
    logic        nreset;
    logic        v_a, v_b;
    logic [79:0] sid;
    logic [63:0] start, cnt;
    logic        tready;

    logic        tv_a, tl_a, drop_a, busy_a;
    logic [63:0] td_a;
    logic [7:0]  tk_a;
    logic        tv_b, tl_b, drop_b, busy_b;
    logic [63:0] td_b;
    logic [7:0]  tk_b;

    mold_req_sched dut_a (
        .clk                  (clk),
        .nreset               (nreset),
        .miss_seq_num_v_i     (v_a),
        .miss_seq_num_sid_i   (sid),
        .miss_seq_num_start_i (start),
        .miss_seq_num_cnt_i   (cnt),
        .req_axis_tvalid_o    (tv_a),
        .req_axis_tdata_o     (td_a),
        .req_axis_tkeep_o     (tk_a),
        .req_axis_tlast_o     (tl_a),
        .req_axis_tready_i    (tready),
        .req_drop_o           (drop_a),
        .req_busy_o           (busy_a)
    );

    mold_req_sched #(
        .MAX_REQ_CNT (16'h0002),
        .GAP_CYCLES  (0)
    ) dut_b (
        .clk                  (clk),
        .nreset               (nreset),
        .miss_seq_num_v_i     (v_b),
        .miss_seq_num_sid_i   (sid),
        .miss_seq_num_start_i (start),
        .miss_seq_num_cnt_i   (cnt),
        .req_axis_tvalid_o    (tv_b),
        .req_axis_tdata_o     (td_b),
        .req_axis_tkeep_o     (tk_b),
        .req_axis_tlast_o     (tl_b),
        .req_axis_tready_i    (tready),
        .req_drop_o           (drop_b),
        .req_busy_o           (busy_b)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: expected beats per instance, pending entry count, drop flag
    // ------------------------------------------------------------------
    beat_t qa[$];
    beat_t qb[$];
    int    pend  [2] = '{0, 0};
    bit    edrop [2] = '{1'b0, 1'b0};

    function automatic int qsize(input int w);
        return (w == 0) ? qa.size() : qb.size();
    endfunction

    function automatic beat_t qfront(input int w);
        return (w == 0) ? qa[0] : qb[0];
    endfunction

    task automatic qpush(input int w, input beat_t b);
        if (w == 0) qa.push_back(b); else qb.push_back(b);
    endtask

    task automatic qpop(input int w);
        if (w == 0) void'(qa.pop_front()); else void'(qb.pop_front());
    endtask

    task automatic qclear(input int w);
        if (w == 0) qa.delete(); else qb.delete();
    endtask

    // Split one gap into requests and lay out each 20-byte request as 3 beats.
    task automatic add_entry(input int w, input logic [79:0] s, input logic [63:0] st,
                             input logic [63:0] c, input logic [15:0] maxc);
        logic [63:0]  rem;
        logic [63:0]  seq;
        logic [15:0]  n;
        logic [159:0] vec;
        beat_t        b;
        rem = c;
        seq = st;
        while (rem != 64'd0) begin
            n   = (rem > {48'd0, maxc}) ? maxc : rem[15:0];
            vec = {n, seq, s};
            b.data = vec[63:0];    b.keep = 8'hFF; b.last = 1'b0; b.done = 1'b0; qpush(w, b);
            b.data = vec[127:64];  qpush(w, b);
            rem = rem - {48'd0, n};
            seq = seq + {48'd0, n};
            b.data = {32'd0, vec[159:128]}; b.keep = 8'h0F; b.last = 1'b1; b.done = (rem == 64'd0);
            qpush(w, b);
        end
    endtask

    task automatic cmp(input int w, input logic v, input logic tv, input logic [63:0] td,
                       input logic [7:0] tk, input logic tl, input logic drop,
                       input logic busy, input logic [15:0] maxc);
        string p;
        beat_t b;
        p = (w == 0) ? "a" : "b";
        if (!nreset) begin
            chk({p, ".rst_tvalid"}, {63'd0, tv}, 64'd0);
            chk({p, ".rst_tdata"}, td, 64'd0);
            chk({p, ".rst_drop"}, {63'd0, drop}, 64'd0);
            chk({p, ".rst_busy"}, {63'd0, busy}, 64'd0);
            qclear(w);
            pend[w]  = 0;
            edrop[w] = 1'b0;
            return;
        end
        chk({p, ".drop"}, {63'd0, drop}, {63'd0, edrop[w]});
        edrop[w] = v && (cnt != 64'd0) && (pend[w] >= 4);
        if (tv) begin
            if (qsize(w) == 0) begin
                tests++;
                fails++;
                $display("FAIL %s.unexpected_beat: actual=%0h required=none (cycle %0d)", p, td, cyc);
            end else begin
                b = qfront(w);
                chk({p, ".tdata"}, td, b.data);
                chk({p, ".tkeep"}, {56'd0, tk}, {56'd0, b.keep});
                chk({p, ".tlast"}, {63'd0, tl}, {63'd0, b.last});
                if (tready) begin
                    qpop(w);
                    if (b.done) pend[w]--;
                end
            end
        end else begin
            chk({p, ".idle_tdata"}, td, 64'd0);
            chk({p, ".idle_tkeep"}, {56'd0, tk}, 64'd0);
            chk({p, ".idle_tlast"}, {63'd0, tl}, 64'd0);
        end
        if (pend[w] > 0) chk({p, ".busy"}, {63'd0, busy}, 64'd1);
        if (v && (cnt != 64'd0) && !edrop[w]) begin
            pend[w]++;
            add_entry(w, sid, start, cnt, maxc);
        end
    endtask

    always @(negedge clk) begin
        cmp(0, v_a, tv_a, td_a, tk_a, tl_a, drop_a, busy_a, 16'hfffe);
        cmp(1, v_b, tv_b, td_b, tk_b, tl_b, drop_b, busy_b, 16'h0002);
    end

    // ------------------------------------------------------------------
    // Capture of accepted beats for directed literal/timing checks
    // ------------------------------------------------------------------
    logic [63:0] cap_a[$];
    int          capc_a[$];
    logic [63:0] cap_b[$];
    int          capc_b[$];
    int          drops_a = 0;
    int          drops_b = 0;

    always @(negedge clk) begin
        if (nreset === 1'b1 && tv_a && tready) begin
            cap_a.push_back(td_a);
            capc_a.push_back(cyc);
        end
        if (nreset === 1'b1 && tv_b && tready) begin
            cap_b.push_back(td_b);
            capc_b.push_back(cyc);
        end
        if (drop_a) drops_a++;
        if (drop_b) drops_b++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic report(input int w, input logic [79:0] s, input logic [63:0] st,
                          input logic [63:0] c);
        sid   = s;
        start = st;
        cnt   = c;
        if (w == 0) v_a = 1'b1; else v_b = 1'b1;
        tick(1);
        v_a = 1'b0;
        v_b = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            tick(1);
            if (!busy_a && !busy_b && !tv_a && !tv_b && qa.size() == 0 && qb.size() == 0)
                done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s.timeout: actual=busy required=idle within 2000 cycles", name);
        end
        tick(2);
    endtask

    task automatic clear_caps();
        cap_a.delete();
        capc_a.delete();
        cap_b.delete();
        capc_b.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int k;
        int d;
        nreset = 1'b1;
        v_a = 1'b0; v_b = 1'b0;
        sid = '0; start = '0; cnt = '0;
        tready = 1'b1;
        #2 nreset = 1'b0;
        tick(3);
        chk("reset_tvalid", {63'd0, tv_a}, 64'd0);
        chk("reset_busy", {63'd0, busy_a}, 64'd0);
        chk("reset_tkeep", {56'd0, tk_a}, 64'd0);
        nreset = 1'b1;
        tick(2);

        // Single 3-message gap: layout and k+2 latency.
        clear_caps();
        k = cyc;
        report(0, 80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 64'd3);
        wait_idle("single");
        chk("single.beats", cap_a.size(), 3);
        chk("single.beat0", cap_a[0], 64'h00000000DEADBEEF);
        chk("single.beat1", cap_a[1], 64'hF0F0F0F0F0F00000);
        chk("single.beat2", cap_a[2], 64'h000000000003F0F0);
        chk("single.latency", capc_a[0], k + 2);

        // 131069 messages split into fffe / fffe / 1.
        clear_caps();
        report(0, 80'h1, 64'h100, 64'h1FFFD);
        wait_idle("split");
        chk("split.beats", cap_a.size(), 9);
        chk("split.r0_beat1", cap_a[1], 64'h0000000001000000);
        chk("split.r0_beat2", cap_a[2], 64'h00000000FFFE0000);
        chk("split.r1_beat1", cap_a[4], 64'h0000000100FE0000);
        chk("split.r2_beat1", cap_a[7], 64'h0000000200FC0000);
        chk("split.r2_beat2", cap_a[8], 64'h0000000000010000);
        // 16 WAIT cycles plus the IDLE dispatch cycle between tlast and next beat0.
        chk("split.gap0", capc_a[3] - capc_a[2], 18);
        chk("split.gap1", capc_a[6] - capc_a[5], 18);

        // Five back-to-back reports while stalled: fifth dropped.
        clear_caps();
        tready = 1'b0;
        d = drops_a;
        for (int i = 1; i <= 5; i++) begin
            sid = 80'(i); start = 64'(i * 100); cnt = 64'd1; v_a = 1'b1;
            tick(1);
        end
        v_a = 1'b0;
        tick(3);
        chk("full.drop_pulses", drops_a - d, 1);
        chk("full.busy", {63'd0, busy_a}, 64'd1);
        tready = 1'b1;
        wait_idle("full");
        chk("full.beats", cap_a.size(), 12);
        chk("full.order0", cap_a[0], 64'd1);
        chk("full.order1", cap_a[3], 64'd2);
        chk("full.order2", cap_a[6], 64'd3);
        chk("full.order3", cap_a[9], 64'd4);

        // Back-pressure 1-0-0-1 around beat1.
        clear_caps();
        k = cyc;
        report(0, 80'h77, 64'h10, 64'd2);
        tick(1);                 // cycle k+2: beat0 accepted
        tick(1); tready = 1'b0;  // k+3
        tick(1);                 // k+4
        tick(1); tready = 1'b1;  // k+5: beat1 accepted
        wait_idle("stall");
        chk("stall.beats", cap_a.size(), 3);
        chk("stall.beat1", cap_a[1], 64'h0000000000100000);
        chk("stall.beat1_cycle", capc_a[1], k + 5);
        chk("stall.beat2_cycle", capc_a[2], k + 6);

        // Sequence wrap with MAX_REQ_CNT=2, GAP_CYCLES=0.
        clear_caps();
        report(1, 80'h5, 64'hFFFFFFFFFFFFFFFF, 64'd3);
        wait_idle("wrap");
        chk("wrap.beats", cap_b.size(), 6);
        chk("wrap.r0_beat1", cap_b[1], 64'hFFFFFFFFFFFF0000);
        chk("wrap.r0_beat2", cap_b[2], 64'h000000000002FFFF);
        chk("wrap.r1_beat1", cap_b[4], 64'h0000000000010000);
        chk("wrap.r1_beat2", cap_b[5], 64'h0000000000010000);
        chk("wrap.gap", capc_b[3] - capc_b[2], 2);

        // Zero-count reports are ignored.
        clear_caps();
        d = drops_a + drops_b;
        report(0, 80'h6, 64'h1, 64'd0);
        report(1, 80'h6, 64'h1, 64'd0);
        tick(3);
        chk("zero.busy_a", {63'd0, busy_a}, 64'd0);
        chk("zero.busy_b", {63'd0, busy_b}, 64'd0);
        chk("zero.drops", drops_a + drops_b - d, 0);
        chk("zero.beats", cap_a.size() + cap_b.size(), 0);

        // Reset during beat1 truncates; next report is clean.
        k = cyc;
        report(0, 80'h9, 64'h20, 64'd3);
        tick(2);                 // cycle k+3: beat1 on the bus
        #2 nreset = 1'b0;
        #1;
        chk("rst.tvalid", {63'd0, tv_a}, 64'd0);
        chk("rst.busy", {63'd0, busy_a}, 64'd0);
        chk("rst.tdata", td_a, 64'd0);
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        tick(1);
        clear_caps();
        report(0, 80'hA, 64'h30, 64'd3);
        wait_idle("post_rst");
        chk("post_rst.beats", cap_a.size(), 3);
        chk("post_rst.beat0", cap_a[0], 64'h000000000000000A);
        chk("post_rst.beat2", cap_a[2], 64'h0000000000030000);

        chk("model.empty_a", qa.size(), 0);
        chk("model.empty_b", qb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
